mmio_uart_ctrl: RTL

- Memory-mapped I/O controller for the execute stage. Decodes CPU loads/stores to the I/O region and arbitrates the shared UART between the CPU and the serial link through RX/TX FIFOs.
- Owns the cycle and retired-instruction counters.
- Sits beside the data memory: it consumes the ALU address, formatted store data and decoded load/store strobes, and returns registered load data to the writeback mux.

---
 rtl/mmio_uart_ctrl_pkg.sv | 45 ++++
 rtl/mmio_uart_ctrl_if.sv | 36 +++
 rtl/mmio_uart_ctrl_sync_fifo.sv | 58 +++++
 rtl/mmio_uart_ctrl.sv | 108 ++++++++++
 4 files changed

// File: rtl/mmio_uart_ctrl_pkg.sv
// rtl/mmio_uart_ctrl_pkg.sv - shared I/O map constants, status bit indices and register decode
//
// Purpose: constants and the offset decoder shared by the MMIO UART controller files.
// Ports:   none (package).
package mmio_uart_ctrl_pkg;

  localparam logic [3:0] IO_NIBBLE_DEFAULT = 4'h8;

  localparam logic [7:0] OFF_STATUS = 8'h00;
  localparam logic [7:0] OFF_RX     = 8'h04;
  localparam logic [7:0] OFF_TX     = 8'h08;
  localparam logic [7:0] OFF_CYC    = 8'h10;
  localparam logic [7:0] OFF_INS    = 8'h14;
  localparam logic [7:0] OFF_CRST   = 8'h18;

  localparam int ST_TX_NOTFULL  = 0;
  localparam int ST_RX_NONEMPTY = 1;
  localparam int ST_TX_OVF      = 2;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_STATUS,
    REG_RX,
    REG_TX,
    REG_CYC,
    REG_INS,
    REG_CRST
  } io_reg_e;

  // Takes the word index addr[7:2]; byte-lane bits never reach the decoder.
  function automatic io_reg_e decode_reg(input logic [5:0] word_idx);
    io_reg_e r;
    case ({word_idx, 2'b00})
      OFF_STATUS: r = REG_STATUS;
      OFF_RX:     r = REG_RX;
      OFF_TX:     r = REG_TX;
      OFF_CYC:    r = REG_CYC;
      OFF_INS:    r = REG_INS;
      OFF_CRST:   r = REG_CRST;
      default:    r = REG_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mmio_uart_ctrl_if.sv
// rtl/mmio_uart_ctrl_if.sv - CPU access bus and UART byte streams of the MMIO UART controller
//
// Purpose: bundles the execute-stage access signals and both UART byte handshakes.
// Ports (signals):
//   addr, wr_data, is_load, is_store, stall, instr_retire : CPU side into the controller
//   load_data                                             : registered load result
//   uart_tx_data/valid/ready                              : byte stream to the transmitter
//   uart_rx_data/valid/ready                              : byte stream from the receiver
// Modports: master = CPU/UART environment, slave = controller.
interface mmio_uart_ctrl_if;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic        is_load;
  logic        is_store;
  logic        stall;
  logic        instr_retire;
  logic [31:0] load_data;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;
  logic        uart_rx_ready;

  modport master (
    output addr, wr_data, is_load, is_store, stall, instr_retire,
    output uart_tx_ready, uart_rx_data, uart_rx_valid,
    input  load_data, uart_tx_data, uart_tx_valid, uart_rx_ready
  );

  modport slave (
    input  addr, wr_data, is_load, is_store, stall, instr_retire,
    input  uart_tx_ready, uart_rx_data, uart_rx_valid,
    output load_data, uart_tx_data, uart_tx_valid, uart_rx_ready
  );
endinterface

// File: rtl/mmio_uart_ctrl_sync_fifo.sv
// rtl/mmio_uart_ctrl_sync_fifo.sv - single-clock FIFO used for the UART RX and TX paths
//
// Purpose: strict-order FIFO, DEPTH a power of two, pointers wrap naturally.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   push_i, din_i   : write request and data (ignored when full)
//   pop_i           : read request (ignored when empty)
//   dout_o          : head entry, combinational; 0 while empty
//   full_o, empty_o : occupancy flags
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  // Full/empty are sampled before this cycle's opposite operation, so a push
  // into a full FIFO is dropped even when a pop happens in the same cycle.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  // Zero while empty keeps the TX byte output clean after reset.
  assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/mmio_uart_ctrl.sv
// rtl/mmio_uart_ctrl.sv - execute-stage MMIO decode, UART RX/TX FIFOs and cycle/instret counters
//
// Purpose: serves CPU loads/stores to the I/O region, bridges the UART through
//          two FIFOs and owns the cycle and retired-instruction counters.
// Ports:
//   clk : system clock
//   rst : asynchronous active-low reset
//   bus : mmio_uart_ctrl_if.slave (CPU access, load_data, UART TX/RX streams)
module mmio_uart_ctrl
  import mmio_uart_ctrl_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [3:0]  IO_NIBBLE  = IO_NIBBLE_DEFAULT
) (
  input logic             clk,
  input logic             rst,
  mmio_uart_ctrl_if.slave bus
);
  logic        io_acc, io_ld, io_st;
  io_reg_e     reg_sel;
  logic        rx_push, rx_pop, rx_full, rx_empty;
  logic        tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]  rx_dout;
  logic        tx_ovf_q, tx_ovf_d;
  logic [31:0] load_data_q, load_data_d;
  logic [31:0] cycle_q, cycle_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] status_word;
  logic        unused_bits;

  assign io_acc  = (bus.is_load | bus.is_store) & (bus.addr[31:28] == IO_NIBBLE) & ~bus.stall;
  assign io_ld   = io_acc & bus.is_load;
  assign io_st   = io_acc & bus.is_store;
  assign reg_sel = decode_reg(bus.addr[7:2]);

  assign unused_bits = ^{bus.addr[27:8], bus.addr[1:0], bus.wr_data[31:8]};

  assign rx_push = bus.uart_rx_valid & ~rx_full;
  assign rx_pop  = io_ld & (reg_sel == REG_RX);
  assign tx_push = io_st & (reg_sel == REG_TX);
  assign tx_pop  = ~tx_empty & bus.uart_tx_ready;

  assign bus.uart_rx_ready = ~rx_full;
  assign bus.uart_tx_valid = ~tx_empty;
  assign bus.load_data     = load_data_q;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst),
    .push_i(rx_push), .din_i(bus.uart_rx_data), .pop_i(rx_pop),
    .dout_o(rx_dout), .full_o(rx_full), .empty_o(rx_empty)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst),
    .push_i(tx_push), .din_i(bus.wr_data[7:0]), .pop_i(tx_pop),
    .dout_o(bus.uart_tx_data), .full_o(tx_full), .empty_o(tx_empty)
  );

  always_comb begin
    status_word                 = '0;
    status_word[ST_TX_NOTFULL]  = ~tx_full;
    status_word[ST_RX_NONEMPTY] = ~rx_empty;
    status_word[ST_TX_OVF]      = tx_ovf_q;
  end

  // A status read reports the old overflow flag and clears it; a dropped push sets it.
  always_comb begin
    tx_ovf_d = tx_ovf_q;
    if (io_ld && reg_sel == REG_STATUS) tx_ovf_d = 1'b0;
    if (tx_push && tx_full)             tx_ovf_d = 1'b1;
  end

  always_comb begin
    load_data_d = '0;
    if (io_ld) begin
      case (reg_sel)
        REG_STATUS: load_data_d = status_word;
        REG_RX:     load_data_d = {24'b0, rx_dout};
        REG_CYC:    load_data_d = cycle_q;
        REG_INS:    load_data_d = instr_q;
        default:    load_data_d = '0;
      endcase
    end
  end

  always_comb begin
    cycle_d = cycle_q + 32'd1;
    instr_d = instr_q + {31'b0, bus.instr_retire};
    if (io_st && reg_sel == REG_CRST) begin
      cycle_d = '0;
      instr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_ovf_q    <= 1'b0;
      load_data_q <= '0;
      cycle_q     <= '0;
      instr_q     <= '0;
    end else begin
      tx_ovf_q    <= tx_ovf_d;
      load_data_q <= load_data_d;
      cycle_q     <= cycle_d;
      instr_q     <= instr_d;
    end
  end
endmodule
